metronome_click_gen: RTL and testbench

METRONOME_CLICK_GEN -- requirements
Module: metronome_click_gen

---
 rtl/metronome_click_gen_pkg.sv | 28 ++
 rtl/metronome_click_gen_if.sv | 23 ++
 rtl/metronome_click_gen_click_osc.sv | 52 +++++
 rtl/metronome_click_gen.sv | 112 +++++++++++
 tb/tb_metronome_click_gen.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/metronome_click_gen_pkg.sv
// Shared types and defaults for the metronome click generator and its
// companion metronome FSM.
package metronome_click_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    localparam int unsigned CLICK_LEN_DEF     = 960;
    localparam int unsigned HALF_PER_NORM_DEF = 24;
    localparam int unsigned HALF_PER_ACC_DEF  = 12;
    localparam int unsigned AMP_START_DEF     = 12000;
    localparam int unsigned BEATS_PER_BAR_DEF = 4;

    localparam int unsigned AMP_W    = 15;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SPEED_W  = 3;
    localparam int unsigned BEAT_W   = 2;

    localparam logic [SPEED_W-1:0] SPEED_STOP = 3'd0;

    // Exponential decay by 1/128 per sample; never drops below zero.
    function automatic logic [AMP_W-1:0] amp_decay(input logic [AMP_W-1:0] a);
        return a - (a >> 7);
    endfunction

endpackage

// File: rtl/metronome_click_gen_if.sv
// Codec/metronome-side signal bundle for the click generator.
interface metronome_click_gen_if;
    import metronome_click_gen_pkg::*;

    logic                       tick;
    logic [SPEED_W-1:0]         speed;
    logic                       sample_req;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_valid;
    logic                       click_active;
    logic [BEAT_W-1:0]          beat_idx;

    modport master (
        output tick, speed, sample_req,
        input  sample, sample_valid, click_active, beat_idx
    );

    modport slave (
        input  tick, speed, sample_req,
        output sample, sample_valid, click_active, beat_idx
    );

endinterface

// File: rtl/metronome_click_gen_click_osc.sv
// Square-wave oscillator with decaying amplitude envelope; produces the
// current signed sample combinationally from its registered state.
module click_osc
    import metronome_click_gen_pkg::*;
#(
    parameter int unsigned HALF_W    = 5,
    parameter int unsigned AMP_START = AMP_START_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load,
    input  logic                       i_step,
    input  logic [HALF_W-1:0]          i_half,
    output logic signed [SAMPLE_W-1:0] o_sample
);

    logic [HALF_W-1:0]          r_half;
    logic [HALF_W-1:0]          r_phase;
    logic                       r_neg;
    logic [AMP_W-1:0]           r_amp;
    logic signed [SAMPLE_W-1:0] w_mag;

    // Load wins over step so a restart colliding with a sample request
    // leaves the freshly loaded state for the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half  <= '0;
            r_phase <= '0;
            r_neg   <= 1'b0;
            r_amp   <= '0;
        end else if (i_load) begin
            r_half  <= i_half;
            r_phase <= '0;
            r_neg   <= 1'b0;
            r_amp   <= AMP_W'(AMP_START);
        end else if (i_step) begin
            if (r_phase == r_half - HALF_W'(1)) begin
                r_phase <= '0;
                r_neg   <= ~r_neg;
            end else begin
                r_phase <= r_phase + HALF_W'(1);
            end
            r_amp <= amp_decay(r_amp);
        end
    end

    always_comb begin
        w_mag    = $signed({1'b0, r_amp});
        o_sample = r_neg ? -w_mag : w_mag;
    end

endmodule

// File: rtl/metronome_click_gen.sv
// Metronome click generator: tick edge detect, IDLE/PLAY FSM, beat counter
// and registered sample output around the click oscillator.
module metronome_click_gen
    import metronome_click_gen_pkg::*;
#(
    parameter int unsigned CLICK_LEN     = CLICK_LEN_DEF,
    parameter int unsigned HALF_PER_NORM = HALF_PER_NORM_DEF,
    parameter int unsigned HALF_PER_ACC  = HALF_PER_ACC_DEF,
    parameter int unsigned AMP_START     = AMP_START_DEF,
    parameter int unsigned BEATS_PER_BAR = BEATS_PER_BAR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    metronome_click_gen_if.slave bus
);

    localparam int unsigned HALF_MAX = (HALF_PER_NORM > HALF_PER_ACC) ? HALF_PER_NORM : HALF_PER_ACC;
    localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);
    localparam int unsigned CNT_W    = $clog2(CLICK_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLICK_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_BAR - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_tick;
    logic                       r_armed;
    logic [BEAT_W-1:0]          r_beat;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic                       r_valid;

    logic                       w_trig;
    logic                       w_accept;
    logic                       w_step;
    logic                       w_last;
    logic [BEAT_W-1:0]          w_beat_next;
    logic [HALF_W-1:0]          w_half;
    logic signed [SAMPLE_W-1:0] w_osc_sample;

    // r_armed blocks the first cycle after reset so a tick already high
    // at release is absorbed into r_tick rather than seen as an edge.
    assign w_trig      = bus.tick & ~r_tick & r_armed;
    assign w_accept    = w_trig & (bus.speed != SPEED_STOP);
    assign w_step      = (r_state == ST_PLAY) & bus.sample_req;
    assign w_last      = w_step & (r_cnt == CNT_LAST);
    assign w_beat_next = (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
    assign w_half      = (w_beat_next == '0) ? HALF_W'(HALF_PER_ACC) : HALF_W'(HALF_PER_NORM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_PLAY;
            ST_PLAY: begin
                if (w_accept)    w_state_next = ST_PLAY;
                else if (w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick   <= 1'b0;
            r_armed  <= 1'b0;
            r_beat   <= BEAT_LAST;
            r_cnt    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_tick  <= bus.tick;
            r_armed <= 1'b1;
            if (w_accept) begin
                r_beat <= w_beat_next;
            end
            if (w_accept || w_last) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_valid <= bus.sample_req;
            if (bus.sample_req) begin
                r_sample <= (r_state == ST_PLAY) ? w_osc_sample : '0;
            end
        end
    end

    click_osc #(
        .HALF_W   (HALF_W),
        .AMP_START(AMP_START)
    ) u_osc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_step  (w_step),
        .i_half  (w_half),
        .o_sample(w_osc_sample)
    );

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.click_active = (r_state == ST_PLAY);
    assign bus.beat_idx     = r_beat;

endmodule

// File: tb/tb_metronome_click_gen.sv
// Directed, table-driven bench for metronome_click_gen.
module tb_metronome_click_gen;
    import metronome_click_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    metronome_click_gen_if u_if();

    metronome_click_gen #(
        .CLICK_LEN    (960),
        .HALF_PER_NORM(24),
        .HALF_PER_ACC (12),
        .AMP_START    (12000),
        .BEATS_PER_BAR(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    int n_run  = 0;
    int n_fail = 0;
    int amp_tab[960];

    typedef struct {
        logic [2:0] speed;
        int         hold;
        int         exp_beat;
        int         exp_active;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_sample(input int n, input int half);
        return (((n / half) % 2) == 0) ? amp_tab[n] : -amp_tab[n];
    endfunction

    task automatic req_sample(input bit with_tick, output int s);
        @(negedge clk);
        u_if.sample_req = 1'b1;
        if (with_tick) u_if.tick = 1'b1;
        @(negedge clk);
        u_if.sample_req = 1'b0;
        if (with_tick) u_if.tick = 1'b0;
        check("sample_valid", int'(u_if.sample_valid), 1);
        s = int'(u_if.sample);
        @(negedge clk);
        check("valid_single_pulse", int'(u_if.sample_valid), 0);
        check("sample_hold", int'(u_if.sample), s);
    endtask

    task automatic play(input int half, input int first, input int last);
        int s;
        for (int n = first; n <= last; n++) begin
            req_sample(1'b0, s);
            check($sformatf("sample[%0d]", n), s, exp_sample(n, half));
            check($sformatf("click_active[%0d]", n), int'(u_if.click_active), (n < 959) ? 1 : 0);
        end
    endtask

    task automatic idle_samples(input int cnt);
        int s;
        for (int k = 0; k < cnt; k++) begin
            req_sample(1'b0, s);
            check("idle_sample", s, 0);
            check("idle_active", int'(u_if.click_active), 0);
        end
    endtask

    task automatic tick_pulse(input int hold);
        @(negedge clk);
        u_if.tick = 1'b1;
        repeat (hold) @(negedge clk);
        u_if.tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;

        amp_tab[0] = 12000;
        for (int i = 1; i < 960; i++) amp_tab[i] = amp_tab[i-1] - (amp_tab[i-1] / 128);

        // After reset beat_idx is 3, so the accepted ticks count 0,1,2,3,0.
        vecs[0] = '{speed: 3'd1, hold: 1, exp_beat: 0, exp_active: 1};
        vecs[1] = '{speed: 3'd2, hold: 4, exp_beat: 1, exp_active: 1};
        vecs[2] = '{speed: 3'd0, hold: 1, exp_beat: 1, exp_active: 0};
        vecs[3] = '{speed: 3'd3, hold: 1, exp_beat: 2, exp_active: 1};
        vecs[4] = '{speed: 3'd0, hold: 3, exp_beat: 2, exp_active: 0};
        vecs[5] = '{speed: 3'd1, hold: 1, exp_beat: 3, exp_active: 1};
        vecs[6] = '{speed: 3'd7, hold: 2, exp_beat: 0, exp_active: 1};

        rst_n           = 1'b1;
        u_if.tick       = 1'b0;
        u_if.speed      = 3'd0;
        u_if.sample_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sample", int'(u_if.sample), 0);
        check("rst_valid", int'(u_if.sample_valid), 0);
        check("rst_active", int'(u_if.click_active), 0);
        check("rst_beat", int'(u_if.beat_idx), 3);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            u_if.speed = vecs[v].speed;
            tick_pulse(vecs[v].hold);
            check($sformatf("vec%0d_beat", v), int'(u_if.beat_idx), vecs[v].exp_beat);
            check($sformatf("vec%0d_active", v), int'(u_if.click_active), vecs[v].exp_active);
            if (vecs[v].exp_active != 0) begin
                play((vecs[v].exp_beat == 0) ? 12 : 24, 0, 959);
                check($sformatf("vec%0d_done", v), int'(u_if.click_active), 0);
            end else begin
                idle_samples(3);
                check($sformatf("vec%0d_beat_kept", v), int'(u_if.beat_idx), vecs[v].exp_beat);
            end
        end

        // Restart colliding with sample 500; then stop speed mid-click.
        u_if.speed = 3'd1;
        tick_pulse(1);
        check("coll_beat_a", int'(u_if.beat_idx), 1);
        play(24, 0, 499);
        req_sample(1'b1, s);
        check("coll_old_sample", s, exp_sample(500, 24));
        check("coll_active", int'(u_if.click_active), 1);
        check("coll_beat_b", int'(u_if.beat_idx), 2);
        u_if.speed = 3'd0;
        play(24, 0, 959);
        check("stop_done", int'(u_if.click_active), 0);
        check("stop_beat", int'(u_if.beat_idx), 2);

        // Mid-click reset with tick held high through release.
        u_if.speed = 3'd1;
        tick_pulse(1);
        check("mr_beat_a", int'(u_if.beat_idx), 3);
        tick_pulse(1);
        check("mr_beat_b", int'(u_if.beat_idx), 0);
        play(12, 0, 99);
        @(negedge clk);
        u_if.tick = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("mr_sample", int'(u_if.sample), 0);
        check("mr_valid", int'(u_if.sample_valid), 0);
        check("mr_active", int'(u_if.click_active), 0);
        check("mr_beat_rst", int'(u_if.beat_idx), 3);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mr_no_click", int'(u_if.click_active), 0);
        check("mr_beat_kept", int'(u_if.beat_idx), 3);
        idle_samples(3);
        u_if.tick = 1'b0;
        repeat (2) @(negedge clk);
        tick_pulse(1);
        check("mr_first_beat", int'(u_if.beat_idx), 0);
        check("mr_first_active", int'(u_if.click_active), 1);
        play(12, 0, 13);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
